// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the accumulate half of the sequential MAC datapath:
// state encoding, default product width and accumulator sizing helper.
package product_accumulator_pkg;

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } acc_state_t;

    localparam int DEF_PROD_W = 16;

    // Smallest accumulator width that can never saturate for a given group size.
    function automatic int min_acc_w(input int prod_w, input int n_terms);
        return prod_w + $clog2(n_terms);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, finished group sum out, plus the synchronous abort.
interface product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20
);
    logic              clear;
    logic              in_valid;
    logic [PROD_W-1:0] in_product;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_overflow;
    logic [7:0]        term_count;

    modport master (
        output clear, in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, term_count
    );

    modport slave (
        input  clear, in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, term_count
    );
endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Combinational unsigned saturating adder: ACC_W-bit running sum plus a
// zero-extended PROD_W-bit product, clamped to all-ones on carry out.
module product_accumulator_sat_adder #(
    parameter int ACC_W  = 20,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_addend,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);
    logic [ACC_W:0] w_full;

    // Add one bit wider than the accumulator so the carry is visible.
    always_comb begin
        w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_addend};
        o_carry = w_full[ACC_W];
        if (o_carry) begin
            o_sum = '1;
        end else begin
            o_sum = w_full[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products into a saturating accumulator and presents
// each finished group on a registered valid/ready result port.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    product_accumulator_if.slave  bus
);
    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_sum;
    logic [ACC_W-1:0] w_sum;
    logic [7:0]       r_count;
    logic             r_ovf;
    logic             r_out_ovf;
    logic             r_out_valid;
    logic             w_carry;
    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic             w_ovf_nxt;

    product_accumulator_sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .i_acc    (r_acc),
        .i_addend (bus.in_product),
        .o_sum    (w_sum),
        .o_carry  (w_carry)
    );

    assign w_accept  = (r_state == S_ACC) && bus.in_valid;
    assign w_last    = (r_count == LAST_CNT);
    assign w_release = r_out_valid && bus.out_ready;
    assign w_ovf_nxt = r_ovf | w_carry;

    // Next-state decode; clear overrides every handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = S_ACC;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept && w_last) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end
                S_HOLD: begin
                    if (w_release) begin
                        w_state_nxt = S_ACC;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                default: w_state_nxt = S_ACC;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, term counter, sticky overflow and the registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= 8'd0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.clear) begin
            // The result registers keep their last value; only the handshake drops.
            r_acc       <= '0;
            r_count     <= 8'd0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_ovf   <= w_ovf_nxt;
                        r_count <= r_count + 8'd1;
                        if (w_last) begin
                            r_out_sum   <= w_sum;
                            r_out_ovf   <= w_ovf_nxt;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_release) begin
                        r_acc       <= '0;
                        r_count     <= 8'd0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_acc       <= '0;
                    r_count     <= 8'd0;
                    r_ovf       <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = (r_state == S_ACC);
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_out_sum;
    assign bus.out_overflow = r_out_ovf;
    assign bus.term_count   = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Three accumulator configurations (4 terms/20 bits, 4 terms/16 bits, 1 term/20 bits)
// driven with directed and random groups and checked against a plain-arithmetic group model.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int     nterms [3] = '{4, 4, 1};
    int     accw   [3] = '{20, 16, 20};
    longint msum     [3];
    int     mcnt     [3];
    longint last_sum [3];
    logic   last_ovf [3];

    logic        clr  [3];
    logic        iv   [3];
    logic        ordy [3];
    logic [15:0] prod [3];
    wire         ir   [3];
    wire         ov   [3];
    wire         oof  [3];
    wire  [19:0] osum [3];
    wire  [7:0]  tc   [3];

    product_accumulator_if #(.PROD_W(16), .ACC_W(20)) if0 ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(16)) if1 ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(20)) if2 ();

    assign if0.clear = clr[0];  assign if0.in_valid = iv[0];
    assign if0.in_product = prod[0];  assign if0.out_ready = ordy[0];
    assign if1.clear = clr[1];  assign if1.in_valid = iv[1];
    assign if1.in_product = prod[1];  assign if1.out_ready = ordy[1];
    assign if2.clear = clr[2];  assign if2.in_valid = iv[2];
    assign if2.in_product = prod[2];  assign if2.out_ready = ordy[2];

    assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign oof[0] = if0.out_overflow;
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign oof[1] = if1.out_overflow;
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign oof[2] = if2.out_overflow;
    assign osum[0] = if0.out_sum;  assign osum[1] = {4'd0, if1.out_sum};  assign osum[2] = if2.out_sum;
    assign tc[0] = if0.term_count;  assign tc[1] = if1.term_count;  assign tc[2] = if2.term_count;

    product_accumulator #(.PROD_W(16), .N_TERMS(4), .ACC_W(20)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    product_accumulator #(.PROD_W(16), .N_TERMS(4), .ACC_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    product_accumulator #(.PROD_W(16), .N_TERMS(1), .ACC_W(20)) u_dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint maxv(input int d);
        return (longint'(1) << accw[d]) - longint'(1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int d);
        msum[d] = 0;
        mcnt[d] = 0;
    endtask

    // Offer one product; it must be taken on the next edge.
    task automatic push(input int d, input int unsigned p);
        chk($sformatf("in_ready_before_push%0d", d), 64'(ir[d]), 64'd1);
        iv[d]   = 1'b1;
        prod[d] = 16'(p);
        step();
        iv[d] = 1'b0;
        msum[d] += longint'(p);
        mcnt[d]++;
        chk($sformatf("term_count%0d", d), 64'(tc[d]), 64'(mcnt[d]));
        if (mcnt[d] == nterms[d]) begin
            last_sum[d] = (msum[d] > maxv(d)) ? maxv(d) : msum[d];
            last_ovf[d] = (msum[d] > maxv(d));
            chk($sformatf("out_valid_rise%0d", d), 64'(ov[d]), 64'd1);
            chk($sformatf("out_sum%0d", d), 64'(osum[d]), 64'(last_sum[d]));
            chk($sformatf("out_overflow%0d", d), 64'(oof[d]), 64'(last_ovf[d]));
            chk($sformatf("in_ready_hold%0d", d), 64'(ir[d]), 64'd0);
        end else begin
            chk($sformatf("out_valid_low%0d", d), 64'(ov[d]), 64'd0);
        end
    endtask

    // Back-pressure a pending result while offering a stray product of 7.
    task automatic hold(input int d, input int k);
        ordy[d] = 1'b0;
        iv[d]   = 1'b1;
        prod[d] = 16'd7;
        for (int i = 0; i < k; i++) begin
            step();
            chk($sformatf("hold_valid%0d", d), 64'(ov[d]), 64'd1);
            chk($sformatf("hold_sum%0d", d), 64'(osum[d]), 64'(last_sum[d]));
            chk($sformatf("hold_in_ready%0d", d), 64'(ir[d]), 64'd0);
            chk($sformatf("hold_count%0d", d), 64'(tc[d]), 64'(nterms[d]));
        end
        iv[d] = 1'b0;
    endtask

    task automatic release_result(input int d);
        ordy[d] = 1'b1;
        step();
        chk($sformatf("release_valid%0d", d), 64'(ov[d]), 64'd0);
        chk($sformatf("release_in_ready%0d", d), 64'(ir[d]), 64'd1);
        chk($sformatf("release_count%0d", d), 64'(tc[d]), 64'd0);
        chk($sformatf("release_sum_kept%0d", d), 64'(osum[d]), 64'(last_sum[d]));
        chk($sformatf("release_ovf_kept%0d", d), 64'(oof[d]), 64'(last_ovf[d]));
        model_reset(d);
    endtask

    // Abort with a product offered at the same time; it must be dropped.
    task automatic clear_pulse(input int d);
        clr[d]  = 1'b1;
        iv[d]   = 1'b1;
        prod[d] = 16'd99;
        step();
        clr[d] = 1'b0;
        iv[d]  = 1'b0;
        chk($sformatf("clear_count%0d", d), 64'(tc[d]), 64'd0);
        chk($sformatf("clear_valid%0d", d), 64'(ov[d]), 64'd0);
        chk($sformatf("clear_in_ready%0d", d), 64'(ir[d]), 64'd1);
        model_reset(d);
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_in_ready%0d", tag, d), 64'(ir[d]), 64'd1);
            chk($sformatf("%s_out_valid%0d", tag, d), 64'(ov[d]), 64'd0);
            chk($sformatf("%s_out_sum%0d", tag, d), 64'(osum[d]), 64'd0);
            chk($sformatf("%s_out_ovf%0d", tag, d), 64'(oof[d]), 64'd0);
            chk($sformatf("%s_count%0d", tag, d), 64'(tc[d]), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b0;  iv[d] = 1'b0;  ordy[d] = 1'b1;  prod[d] = 16'd0;
            last_sum[d] = 0;  last_ovf[d] = 1'b0;
            model_reset(d);
        end
        #1;
        check_reset_state("reset");
        #1;
        reset = 1'b0;

        // Basic group, then an immediate second group at minimum period.
        push(0, 100); push(0, 200); push(0, 300); push(0, 400);
        release_result(0);
        push(0, 5); push(0, 6); push(0, 7); push(0, 8);
        release_result(0);

        // Saturation on a 16-bit accumulator, then a clean group.
        push(1, 65535); push(1, 1); push(1, 0); push(1, 0);
        release_result(1);
        push(1, 5); push(1, 5); push(1, 5); push(1, 5);
        release_result(1);

        // Back-pressure: the stray 7s must never land in any sum.
        push(0, 10); push(0, 10); push(0, 10); push(0, 10);
        hold(0, 5);
        release_result(0);
        push(0, 1); push(0, 1); push(0, 1); push(0, 1);
        release_result(0);

        // Abort mid-group, then a fresh group.
        push(0, 50); push(0, 50);
        clear_pulse(0);
        push(0, 1); push(0, 2); push(0, 3); push(0, 4);
        release_result(0);

        // Abort coinciding with out_ready in the hold state.
        push(1, 9); push(1, 9); push(1, 9); push(1, 9);
        clear_pulse(1);
        push(1, 2); push(1, 2); push(1, 2); push(1, 2);
        release_result(1);

        // Asynchronous reset between edges while a result is pending.
        push(0, 3); push(0, 3); push(0, 3); push(0, 3);
        ordy[0] = 1'b0;
        step();
        chk("pre_reset_valid", 64'(ov[0]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        #2;
        reset = 1'b0;
        ordy[0] = 1'b1;
        for (int d = 0; d < 3; d++) begin
            model_reset(d);
            last_sum[d] = 0;
            last_ovf[d] = 1'b0;
        end
        push(0, 8); push(0, 8); push(0, 8); push(0, 8);
        release_result(0);

        // Single-term groups: pulses two cycles apart.
        push(2, 3);
        release_result(2);
        push(2, 9);
        release_result(2);

        // Random groups across all three configurations.
        for (int it = 0; it < 24; it++) begin
            int d;
            d = int'($urandom_range(0, 2));
            for (int j = 0; j < nterms[d]; j++) begin
                int unsigned p;
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    chk($sformatf("idle_count%0d", d), 64'(tc[d]), 64'(mcnt[d]));
                end
                p = ($urandom_range(0, 3) == 0) ? 32'd65535 : $urandom_range(0, 65535);
                push(d, p);
            end
            if ($urandom_range(0, 1) == 1) begin
                hold(d, int'($urandom_range(1, 3)));
            end
            release_result(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
